// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drain stage for a single-clock, non-showahead FIFO. Watches the FIFO fill
// level, issues rdreq pulses (read data arrives one cycle later) and re-presents
// the words as a valid/ready stream grouped into bursts, marking the last beat.
// A two-entry skid buffer absorbs downstream backpressure; a read is only issued
// when the skid buffer is guaranteed to have room for the returning word.
//
// Optional feature macro: FIFO_BURST_READER_TIMEOUT_EN
//   When defined, a partial burst (0 < fill < burst_len) that has waited
//   `timeout` idle cycles is drained as if flush had been pulsed.
//
// Parameters
//   bus_width  : data word width (matches the FIFO)
//   addr_width : FIFO usedw width, depth = 2**addr_width
//   burst_len  : beats per full burst, 1 .. 2**addr_width
//   timeout    : idle cycles before auto-flush (timeout feature only)
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   usedw     in   FIFO fill level (wraps to 0 when full)
//   full      in   FIFO full
//   q         in   FIFO read data, valid the cycle after rdreq
//   rdreq     out  FIFO read request
//   flush     in   drain a partial burst
//   out_data  out  stream data (skid head)
//   out_valid out  stream valid
//   out_ready in   downstream accepts the beat
//   out_last  out  final beat of the burst
//   busy      out  high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int bus_width  = 8,
    parameter int addr_width = 8,
    parameter int burst_len  = 16,
    parameter int timeout    = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [addr_width-1:0] usedw,
    input  logic                  full,
    input  logic [bus_width-1:0]  q,
    output logic                  rdreq,
    input  logic                  flush,
    output logic [bus_width-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int cnt_w = addr_width + 1;
    localparam logic [cnt_w-1:0] burst_len_c = cnt_w'(burst_len);
    localparam logic [cnt_w-1:0] depth_c     = {1'b1, {addr_width{1'b0}}};
    localparam logic [cnt_w-1:0] one_c       = {{addr_width{1'b0}}, 1'b1};
    localparam logic [cnt_w-1:0] zero_c      = {cnt_w{1'b0}};

    state_t                 state_r;
    state_t                 state_n_s;
    logic [cnt_w-1:0]       reads_left_r;
    logic [cnt_w-1:0]       beats_left_r;
    logic [1:0]             occ_r;
    logic                   inflight_r;
    logic [bus_width-1:0]   skid_r [2];
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;

    logic [cnt_w-1:0]       fill_s;
    logic                   pop_s;
    logic [2:0]             level_s;
    logic                   load_s;
    logic [cnt_w-1:0]       len_s;
    logic                   flush_eff_s;

    // usedw wraps to zero at full, so full supplies the missing top bit.
    assign fill_s = full ? depth_c : {1'b0, usedw};

    assign out_valid = (occ_r != 2'd0);
    assign out_data  = skid_r[rd_ptr_r];
    assign out_last  = out_valid && (beats_left_r == one_c);
    assign busy      = (state_r == ST_BURST);
    assign pop_s     = out_valid && out_ready;

    // Words held plus the word returning next edge, less the one leaving now;
    // a new read is allowed only while this stays below the skid depth.
    assign level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rdreq   = (reads_left_r != zero_c) && (level_s < 3'd2);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int tmo_w = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [tmo_w-1:0] timeout_c = tmo_w'(timeout);

    logic [tmo_w-1:0] idle_cnt_r;
    logic             tmo_hit_s;

    assign tmo_hit_s = (state_r == ST_IDLE) && (fill_s != zero_c) &&
                       (fill_s < burst_len_c) && (idle_cnt_r == timeout_c);
    assign flush_eff_s = flush || tmo_hit_s;

    // Idle-wait counter: counts IDLE cycles holding a partial burst, saturating at timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= {tmo_w{1'b0}};
        end else if ((state_r == ST_BURST) || (fill_s == zero_c)) begin
            idle_cnt_r <= {tmo_w{1'b0}};
        end else if ((fill_s < burst_len_c) && (idle_cnt_r != timeout_c)) begin
            idle_cnt_r <= idle_cnt_r + {{(tmo_w-1){1'b0}}, 1'b1};
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (timeout == 32'sd0);
    assign flush_eff_s      = flush;
`endif

    // Next-state logic and burst-length selection; a full burst beats a flush.
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        len_s     = zero_c;
        case (state_r)
            ST_IDLE: begin
                if (fill_s >= burst_len_c) begin
                    state_n_s = ST_BURST;
                    load_s    = 1'b1;
                    len_s     = burst_len_c;
                end else if (flush_eff_s && (fill_s != zero_c)) begin
                    state_n_s = ST_BURST;
                    load_s    = 1'b1;
                    len_s     = fill_s;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (pop_s && (beats_left_r == one_c)) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_BURST;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Burst counters: loaded on entry, then counted down by reads and pops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reads_left_r <= zero_c;
            beats_left_r <= zero_c;
        end else if (load_s) begin
            reads_left_r <= len_s;
            beats_left_r <= len_s;
        end else begin
            reads_left_r <= rdreq ? (reads_left_r - one_c) : reads_left_r;
            beats_left_r <= pop_s ? (beats_left_r - one_c) : beats_left_r;
        end
    end

    // Read-latency tracker and skid occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= 1'b0;
            occ_r      <= 2'd0;
        end else begin
            inflight_r <= rdreq;
            occ_r      <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    // Skid storage: capture returning FIFO data, advance head on pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                skid_r[i] <= {bus_width{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (inflight_r) begin
                skid_r[wr_ptr_r] <= q;
                wr_ptr_r         <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fifo_burst_reader.
// A queue-based FIFO model feeds the main instance; expected beat timing and
// data are derived from the burst rules (entry cycle N, rdreq N+1..N+L, beats
// N+3..N+2+L). A second, small instance (depth 16) is exercised from a table
// of IDLE-entry decisions, including the full/usedw-wrap boundary.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    logic       clock;
    logic       reset_n;
    logic [7:0] usedw;
    logic       full;
    logic [7:0] q;
    logic       rdreq;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    logic [3:0] s_usedw;
    logic       s_full;
    logic [7:0] s_q;
    logic       s_rdreq;
    logic       s_flush;
    logic [7:0] s_out_data;
    logic       s_out_valid;
    logic       s_out_ready;
    logic       s_out_last;
    logic       s_busy;

    int tests = 0;
    int fails = 0;
    int reads_total = 0;
    int outstanding = 0;

    logic [7:0] fifo_mem [$];
    logic [7:0] got_data [$];
    logic       got_last [$];

    typedef struct {
        logic       full;
        logic [3:0] usedw;
        logic       flush;
        logic       go;
        int         len;
    } vec_t;

    vec_t vecs [7];

    fifo_burst_reader #(
        .bus_width(8), .addr_width(8), .burst_len(16), .timeout(10)
    ) dut (
        .clock(clock), .reset_n(reset_n), .usedw(usedw), .full(full), .q(q),
        .rdreq(rdreq), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    fifo_burst_reader #(
        .bus_width(8), .addr_width(4), .burst_len(16), .timeout(255)
    ) dut_small (
        .clock(clock), .reset_n(reset_n), .usedw(s_usedw), .full(s_full), .q(s_q),
        .rdreq(s_rdreq), .flush(s_flush), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_last(s_out_last), .busy(s_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic update_levels();
        usedw = 8'(fifo_mem.size());
        full  = (fifo_mem.size() == 256);
    endtask

    task automatic push(input logic [7:0] w);
        fifo_mem.push_back(w);
        update_levels();
    endtask

    // Called just after a negedge with inputs settled: records this cycle,
    // advances through the rising edge, models the FIFO read, returns at negedge.
    task automatic tick();
        logic rd;
        logic pp;
        rd = rdreq;
        pp = out_valid && out_ready;
        if (pp) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (rd) reads_total++;
        outstanding = outstanding + int'(rd) - int'(pp);
        @(posedge clock);
        #1;
        if (rd) begin
            if (fifo_mem.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL underflow: got rdreq=1 expected 0 on empty FIFO");
            end else begin
                q = fifo_mem.pop_front();
            end
        end
        update_levels();
        check("outstanding_le2", int'(outstanding <= 2), 1);
        @(negedge clock);
    endtask

    // Cycle 0 is the IDLE cycle whose entry condition holds.
    task automatic timeline(input string name, input int len, input logic [7:0] d0,
                            input logic use_flush);
        int         r0;
        logic [7:0] ed;
        r0 = reads_total;
        for (int c = 0; c <= len + 3; c++) begin
            flush = use_flush && (c == 0);
            #1;
            check({name, "_rdreq"}, int'(rdreq), int'(c >= 1 && c <= len));
            check({name, "_valid"}, int'(out_valid), int'(c >= 3 && c <= len + 2));
            check({name, "_last"}, int'(out_last), int'(c == len + 2));
            check({name, "_busy"}, int'(busy), int'(c >= 1 && c <= len + 2));
            if (c >= 3 && c <= len + 2) begin
                ed = d0 + 8'(c - 3);
                check({name, "_data"}, int'(out_data), int'(ed));
            end
            tick();
        end
        flush = 1'b0;
        check({name, "_reads"}, reads_total - r0, len);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_rdreq"}, int'(rdreq), 0);
        check({name, "_valid"}, int'(out_valid), 0);
        check({name, "_last"}, int'(out_last), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_data"}, int'(out_data), 0);
    endtask

    initial begin
        int         r0;
        int         n_rd;
        int         n_pop;
        logic       done;
        logic       stalled;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] head;
        logic [7:0] exp_q [$];

        vecs[0] = '{1'b1, 4'd0,  1'b0, 1'b1, 16};
        vecs[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 4'd15, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 4'd15, 1'b1, 1'b1, 15};
        vecs[4] = '{1'b0, 4'd1,  1'b1, 1'b1, 1};
        vecs[5] = '{1'b1, 4'd0,  1'b1, 1'b1, 16};
        vecs[6] = '{1'b0, 4'd7,  1'b0, 1'b0, 0};

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0; q = 8'd0;
        s_usedw = 4'd0; s_full = 1'b0; s_flush = 1'b0; s_q = 8'd0; s_out_ready = 1'b1;
        update_levels();
        for (int i = 0; i < 20; i++) push(8'(i));

        // Reset state.
        repeat (2) @(negedge clock);
        #1;
        check_zero_outputs("reset");
        @(negedge clock);

        // Full burst straight out of reset, then a flushed partial burst.
        reset_n   = 1'b1;
        out_ready = 1'b1;
        timeline("A", 16, 8'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("A_hold_idle_busy", int'(busy), 0);
            check("A_hold_idle_rdreq", int'(rdreq), 0);
            tick();
        end
        timeline("B", 4, 8'd16, 1'b1);

        // IDLE-entry decisions on a depth-16 instance.
        for (int i = 0; i < 7; i++) begin
            s_full = vecs[i].full; s_usedw = vecs[i].usedw; s_flush = vecs[i].flush;
            #1;
            check($sformatf("E%0d_idle", i), int'(s_busy), 0);
            @(posedge clock);
            #1;
            s_full = 1'b0; s_usedw = 4'd0; s_flush = 1'b0;
            @(negedge clock);
            #1;
            check($sformatf("E%0d_go", i), int'(s_busy), int'(vecs[i].go));
            n_rd = 0; n_pop = 0; done = 1'b0;
            if (vecs[i].go) begin
                for (int k = 0; k < 40 && !done; k++) begin
                    if (s_rdreq) n_rd++;
                    if (s_out_valid && s_out_ready) begin
                        n_pop++;
                        if (s_out_last) done = 1'b1;
                    end
                    @(negedge clock);
                    #1;
                end
                check($sformatf("E%0d_done", i), int'(done), 1);
                check($sformatf("E%0d_reads", i), n_rd, vecs[i].len);
                check($sformatf("E%0d_beats", i), n_pop, vecs[i].len);
                check($sformatf("E%0d_back_idle", i), int'(s_busy), 0);
            end else begin
                check($sformatf("E%0d_no_rdreq", i), int'(s_rdreq), 0);
            end
            @(negedge clock);
        end

        // Random backpressure over a 16-beat burst.
        got_data.delete(); got_last.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            exp_q.push_back(w);
            push(w);
        end
        r0 = reads_total;
        prev_stall = 1'b0; prev_data = 8'd0; prev_last = 1'b0;
        for (int k = 0; k < 400 && got_data.size() < 16; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                check("C_hold_valid", int'(out_valid), 1);
                check("C_hold_data", int'(out_data), int'(prev_data));
                check("C_hold_last", int'(out_last), int'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            tick();
        end
        check("C_beats", got_data.size(), 16);
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            check($sformatf("C_data%0d", i), int'(got_data[i]), int'(exp_q[i]));
            check($sformatf("C_last%0d", i), int'(got_last[i]), int'(i == 15));
        end
        check("C_reads", reads_total - r0, 16);
        out_ready = 1'b1;
        #1;
        check("C_back_idle", int'(busy), 0);
        tick();

        // Reset mid-burst with beat 5 stalled and one read in flight.
        for (int i = 0; i < 30; i++) push(8'h40 + 8'(i));
        r0 = reads_total;
        stalled = 1'b0;
        for (int k = 0; k < 60 && !stalled; k++) begin
            out_ready = 1'b1;
            #1;
            if (out_valid && (out_data == 8'h45)) begin
                stalled = 1'b1;
            end else begin
                tick();
            end
        end
        check("D_stall_reached", int'(stalled), 1);
        out_ready = 1'b0;
        #1;
        check("D_stall_rdreq", int'(rdreq), 0);
        check("D_stall_outstanding", outstanding, 2);
        check("D_reads_before_reset", reads_total - r0, 7);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("D_reset");
        head = 8'h40 + 8'(reads_total - r0);
        tick();
        outstanding = 0;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        timeline("D", 16, head, 1'b0);
        timeline("D2", 7, head + 8'd16, 1'b1);

        // Partial burst with no flush: auto-drain only with the timeout feature.
        push(8'hA0); push(8'hA1); push(8'hA2);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        for (int c = 0; c < 10; c++) begin
            #1;
            check("F_wait_busy", int'(busy), 0);
            check("F_wait_rdreq", int'(rdreq), 0);
            tick();
        end
        timeline("F", 3, 8'hA0, 1'b0);
`else
        for (int c = 0; c < 30; c++) begin
            #1;
            check("F_no_burst_busy", int'(busy), 0);
            check("F_no_burst_rdreq", int'(rdreq), 0);
            tick();
        end
        timeline("F", 3, 8'hA0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
